vaddr_sequencer: RTL and testbench

VADDR_SEQUENCER -- requirements
Module: vaddr_sequencer

---
 rtl/vaddr_seq_pkg.sv | 35 +++
 rtl/vaddr_rr_arbiter.sv | 46 ++++
 rtl/vaddr_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_vaddr_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vaddr_seq_pkg.sv
// vaddr_seq_pkg
//   Shared types and helpers for the vector address sequencer:
//     - state_t     : sequencer FSM states (IDLE -> LOAD -> RUN -> DONE)
//     - sew_t       : element-width encodings, plus SEW_ILLEGAL
//     - calc_aw     : VRF address width from the per-lane depth
//     - calc_vl_w   : vector-length field width from lane count and register size
package vaddr_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SEW_BYTE = 2'b00,
        SEW_HALF = 2'b01,
        SEW_WORD = 2'b10,
        SEW_RSVD = 2'b11
    } sew_t;

    localparam sew_t SEW_ILLEGAL = SEW_RSVD;

    function automatic int calc_aw(input int depth);
        return $clog2(depth);
    endfunction

    // One extra bit so a full-length vector (all lanes, all words, byte
    // elements) is representable rather than wrapping to zero.
    function automatic int calc_vl_w(input int lanes, input int locs);
        return $clog2(lanes * locs * 32) + 1;
    endfunction

endpackage

// File: rtl/vaddr_rr_arbiter.sv
// vaddr_rr_arbiter
//   Two-requester round-robin arbiter.
//   Ports:
//     clk_i     : clock, rising edge
//     rst_i     : synchronous active-high reset (pointer -> requester 0)
//     req_i     : request per requester
//     arb_en_i  : arbitration allowed this cycle (sequencer idle)
//     gnt_o     : combinational one-hot grant, zero when disabled or no request
//   On a contested cycle the pointer picks the winner; after any grant the
//   pointer moves to the requester that did not win.
module vaddr_rr_arbiter (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       arb_en_i,
    output logic [1:0] gnt_o
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        gnt_o = 2'b00;
        ptr_d = ptr_q;
        if (arb_en_i) begin
            case (req_i)
                2'b01:   gnt_o = 2'b01;
                2'b10:   gnt_o = 2'b10;
                2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
                default: gnt_o = 2'b00;
            endcase
            if (gnt_o != 2'b00) begin
                ptr_d = ~gnt_o[1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/vaddr_sequencer.sv
// vaddr_sequencer
//   Accepts vector access requests from two requesters (0 = arith,
//   1 = load/store), captures the winner's configuration and sequences the
//   per-lane address counter: one LOAD cycle, ceil(vl/VLANE_NUM) enabled RUN
//   cycles (held off by stall_i), then a one-cycle DONE.
//   Ports:
//     clk_i, rst_i            : clock, synchronous active-high reset
//     req_valid_i/ready_o     : per-requester handshake, ready one-hot in IDLE
//     req_start_addr_i        : eight packed register base addresses per requester
//     req_vl_i, req_sew_i     : vector length (elements) and element width
//     req_slide_offset_i      : slide offset
//     req_up_down_i           : slide direction (1 up, 0 down)
//     stall_i                 : downstream cannot take an element (RUN only)
//     load_o, rst_cnt_o       : address counter load / clear (LOAD cycle)
//     en_o                    : address counter advance
//     up_down_o, element_width_o, start_addr_o, slide_offset_o : captured config
//     element_valid_o, done_o, busy_o, owner_o : status
//   Build option VADDR_SEQ_SLIDE_EN: when defined, slide offset and direction
//   follow the captured request; otherwise they are fixed at 0 and up.
module vaddr_sequencer
    import vaddr_seq_pkg::*;
#(
    parameter  int MEM_DEPTH         = 512,
    parameter  int VLANE_NUM         = 8,
    parameter  int VREG_LOC_PER_LANE = 8,
    localparam int AW                = calc_aw(MEM_DEPTH),
    localparam int VL_W              = calc_vl_w(VLANE_NUM, VREG_LOC_PER_LANE)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [1:0]               req_valid_i,
    output logic [1:0]               req_ready_o,
    input  logic [1:0][8*AW-1:0]     req_start_addr_i,
    input  logic [1:0][VL_W-1:0]     req_vl_i,
    input  logic [1:0][1:0]          req_sew_i,
    input  logic [1:0][AW-1:0]       req_slide_offset_i,
    input  logic [1:0]               req_up_down_i,
    input  logic                     stall_i,
    output logic                     load_o,
    output logic                     rst_cnt_o,
    output logic                     en_o,
    output logic                     up_down_o,
    output logic [1:0]               element_width_o,
    output logic [8*AW-1:0]          start_addr_o,
    output logic [AW-1:0]            slide_offset_o,
    output logic                     element_valid_o,
    output logic                     done_o,
    output logic                     busy_o,
    output logic                     owner_o
);

    // Elements each lane must process; an illegal width yields an empty run.
    function automatic logic [VL_W-1:0] lane_elems(input logic [VL_W-1:0] vl,
                                                   input logic [1:0]      sew);
        logic [VL_W:0] sum;
        sum = {1'b0, vl} + (VL_W+1)'(VLANE_NUM - 1);
        if (sew == SEW_ILLEGAL) begin
            return '0;
        end
        return VL_W'(sum / (VL_W+1)'(VLANE_NUM));
    endfunction

    state_t          state_q,      state_d;
    logic [VL_W-1:0] cnt_q,        cnt_d;
    logic [8*AW-1:0] start_addr_q, start_addr_d;
    logic [VL_W-1:0] vl_q,         vl_d;
    logic [1:0]      sew_q,        sew_d;
    logic [AW-1:0]   slide_q,      slide_d;
    logic            up_down_q,    up_down_d;
    logic            owner_q,      owner_d;
    logic            load_q,       load_d;
    logic            done_q,       done_d;
    logic            busy_q,       busy_d;

    logic [1:0]      gnt;
    logic            sel;
    logic            run_en;

    vaddr_rr_arbiter u_arb (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .req_i    (req_valid_i),
        .arb_en_i (state_q == ST_IDLE),
        .gnt_o    (gnt)
    );

    assign sel    = gnt[1];
    assign run_en = (state_q == ST_RUN) && !stall_i;

`ifndef VADDR_SEQ_SLIDE_EN
    logic unused_slide_inputs;
    assign unused_slide_inputs = ^{req_slide_offset_i, req_up_down_i};
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        start_addr_d = start_addr_q;
        vl_d         = vl_q;
        sew_d        = sew_q;
        slide_d      = slide_q;
        up_down_d    = up_down_q;
        owner_d      = owner_q;

        case (state_q)
            ST_IDLE: begin
                if (gnt != 2'b00) begin
                    state_d      = ST_LOAD;
                    start_addr_d = req_start_addr_i[sel];
                    vl_d         = req_vl_i[sel];
                    sew_d        = req_sew_i[sel];
                    owner_d      = sel;
`ifdef VADDR_SEQ_SLIDE_EN
                    slide_d      = req_slide_offset_i[sel];
                    up_down_d    = req_up_down_i[sel];
`else
                    slide_d      = '0;
                    up_down_d    = 1'b1;
`endif
                end
            end
            ST_LOAD: begin
                cnt_d   = lane_elems(vl_q, sew_q);
                state_d = (cnt_d == '0) ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                if (run_en) begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == VL_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status outputs are registered: decode the state being entered.
        load_d = (state_d == ST_LOAD);
        done_d = (state_d == ST_DONE);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            start_addr_q <= '0;
            vl_q         <= '0;
            sew_q        <= '0;
            slide_q      <= '0;
            up_down_q    <= 1'b0;
            owner_q      <= 1'b0;
            load_q       <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            start_addr_q <= start_addr_d;
            vl_q         <= vl_d;
            sew_q        <= sew_d;
            slide_q      <= slide_d;
            up_down_q    <= up_down_d;
            owner_q      <= owner_d;
            load_q       <= load_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
        end
    end

    assign req_ready_o     = gnt;
    assign load_o          = load_q;
    assign rst_cnt_o       = load_q;
    assign en_o            = run_en;
    assign element_valid_o = run_en;
    assign done_o          = done_q;
    assign busy_o          = busy_q;
    assign owner_o         = owner_q;
    assign start_addr_o    = start_addr_q;
    assign element_width_o = sew_q;
    assign slide_offset_o  = slide_q;
    assign up_down_o       = up_down_q;

endmodule

// File: tb/tb_vaddr_sequencer.sv
// tb_vaddr_sequencer
//   Randomized and directed stimulus for vaddr_sequencer, checked against a
//   transaction-level model (arbitration pointer, captured config and the
//   expected number of enabled elements per request).
module tb_vaddr_sequencer;
    import vaddr_seq_pkg::*;

    localparam int MEM_DEPTH         = 512;
    localparam int VLANE_NUM         = 8;
    localparam int VREG_LOC_PER_LANE = 8;
    localparam int AW   = $clog2(MEM_DEPTH);
    localparam int VL_W = $clog2(VLANE_NUM * VREG_LOC_PER_LANE * 32) + 1;
`ifdef VADDR_SEQ_SLIDE_EN
    localparam bit SLIDE_EN = 1'b1;
`else
    localparam bit SLIDE_EN = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst_i;
    logic [1:0]           req_valid_i;
    logic [1:0]           req_ready_o;
    logic [1:0][8*AW-1:0] req_start_addr_i;
    logic [1:0][VL_W-1:0] req_vl_i;
    logic [1:0][1:0]      req_sew_i;
    logic [1:0][AW-1:0]   req_slide_offset_i;
    logic [1:0]           req_up_down_i;
    logic                 stall_i;
    logic                 load_o, rst_cnt_o, en_o, up_down_o;
    logic [1:0]           element_width_o;
    logic [8*AW-1:0]      start_addr_o;
    logic [AW-1:0]        slide_offset_o;
    logic                 element_valid_o, done_o, busy_o, owner_o;

    vaddr_sequencer #(
        .MEM_DEPTH(MEM_DEPTH), .VLANE_NUM(VLANE_NUM), .VREG_LOC_PER_LANE(VREG_LOC_PER_LANE)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_start_addr_i(req_start_addr_i), .req_vl_i(req_vl_i),
        .req_sew_i(req_sew_i), .req_slide_offset_i(req_slide_offset_i),
        .req_up_down_i(req_up_down_i), .stall_i(stall_i),
        .load_o(load_o), .rst_cnt_o(rst_cnt_o), .en_o(en_o), .up_down_o(up_down_o),
        .element_width_o(element_width_o), .start_addr_o(start_addr_o),
        .slide_offset_o(slide_offset_o), .element_valid_o(element_valid_o),
        .done_o(done_o), .busy_o(busy_o), .owner_o(owner_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    // Model state
    int              rr_ptr;
    logic [8*AW-1:0] m_addr;
    logic [1:0]      m_sew;
    logic [AW-1:0]   m_slide;
    logic            m_ud;
    logic            m_owner;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic [8*AW-1:0] addr, input int vl,
                           input int sew, input int off, input bit ud);
        req_start_addr_i[r]   = addr;
        req_vl_i[r]           = VL_W'(vl);
        req_sew_i[r]          = 2'(sew);
        req_slide_offset_i[r] = AW'(off);
        req_up_down_i[r]      = ud;
    endtask

    function automatic logic [8*AW-1:0] rand_addr();
        return (8*AW)'({$urandom(), $urandom(), $urandom()});
    endfunction

    task automatic rand_req(input int r);
        int vl;
        vl = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 2048)) : int'($urandom_range(0, 100));
        set_req(r, rand_addr(), vl, int'($urandom_range(0, 3)),
                int'($urandom_range(0, MEM_DEPTH - 1)), 1'($urandom_range(0, 1)));
    endtask

    // Garbage on request inputs while busy; none of it may be taken.
    task automatic scramble();
        req_valid_i = 2'($urandom_range(0, 3));
        rand_req(0);
        rand_req(1);
    endtask

    task automatic check_cfg();
        chk("start_addr", 128'(start_addr_o), 128'(m_addr));
        chk("elem_width", 128'(element_width_o), 128'(m_sew));
        chk("slide_off", 128'(slide_offset_o), 128'(m_slide));
        chk("up_down", 128'(up_down_o), 128'(m_ud));
        chk("owner", 128'(owner_o), 128'(m_owner));
    endtask

    task automatic model_reset();
        rr_ptr  = 0;
        m_addr  = '0;
        m_sew   = '0;
        m_slide = '0;
        m_ud    = 1'b0;
        m_owner = 1'b0;
    endtask

    // Called at posedge+1 of an IDLE cycle with request fields already set.
    // stall_mode: 0 none, 1 random, 2 stall on RUN cycles 2 and 3.
    // rst_at: RUN cycle (1-based) on which rst_i is raised, 0 for none.
    task automatic do_txn(input bit v0, input bit v1, input int stall_mode,
                          input int rst_at, output int run_cycles);
        int   winner;
        int   n_exp;
        int   en_cnt;
        int   vl;
        logic [1:0] sew;
        winner     = (v0 && v1) ? rr_ptr : (v1 ? 1 : 0);
        run_cycles = 0;
        req_valid_i = {v1, v0};
        stall_i     = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("ready_grant", 128'(req_ready_o), 128'(2'b01 << winner));
        chk("idle_busy", 128'(busy_o), 128'(0));
        chk("idle_en", 128'(en_o), 128'(0));
        m_addr  = req_start_addr_i[winner];
        m_sew   = req_sew_i[winner];
        m_slide = SLIDE_EN ? req_slide_offset_i[winner] : '0;
        m_ud    = SLIDE_EN ? req_up_down_i[winner] : 1'b1;
        m_owner = 1'(winner);
        vl      = int'(req_vl_i[winner]);
        sew     = req_sew_i[winner];
        rr_ptr  = 1 - winner;
        n_exp   = (sew == 2'b11) ? 0 : (vl + VLANE_NUM - 1) / VLANE_NUM;

        next_cycle();   // LOAD
        scramble();
        stall_i = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("load", 128'(load_o), 128'(1));
        chk("rst_cnt", 128'(rst_cnt_o), 128'(1));
        chk("load_en", 128'(en_o), 128'(0));
        chk("load_busy", 128'(busy_o), 128'(1));
        chk("load_done", 128'(done_o), 128'(0));
        chk("load_ready", 128'(req_ready_o), 128'(0));
        check_cfg();

        next_cycle();
        en_cnt = 0;
        while (en_cnt < n_exp) begin
            run_cycles++;
            case (stall_mode)
                0:       stall_i = 1'b0;
                1:       stall_i = ($urandom_range(0, 3) == 0);
                default: stall_i = (run_cycles == 2 || run_cycles == 3);
            endcase
            scramble();
            if (rst_at == run_cycles) rst_i = 1'b1;
            @(negedge clk);
            chk("run_en", 128'(en_o), 128'(!stall_i));
            chk("run_elem_valid", 128'(element_valid_o), 128'(!stall_i));
            chk("run_load", 128'(load_o), 128'(0));
            chk("run_done", 128'(done_o), 128'(0));
            chk("run_busy", 128'(busy_o), 128'(1));
            chk("run_ready", 128'(req_ready_o), 128'(0));
            check_cfg();
            if (!stall_i) en_cnt++;
            next_cycle();
            if (rst_at == run_cycles) begin
                rst_i       = 1'b0;
                req_valid_i = 2'b00;
                stall_i     = 1'b0;
                model_reset();
                @(negedge clk);
                chk("rst_load", 128'(load_o), 128'(0));
                chk("rst_rst_cnt", 128'(rst_cnt_o), 128'(0));
                chk("rst_en", 128'(en_o), 128'(0));
                chk("rst_elem_valid", 128'(element_valid_o), 128'(0));
                chk("rst_done", 128'(done_o), 128'(0));
                chk("rst_busy", 128'(busy_o), 128'(0));
                chk("rst_ready", 128'(req_ready_o), 128'(0));
                check_cfg();
                next_cycle();
                @(negedge clk);
                chk("rst_no_done", 128'(done_o), 128'(0));
                chk("rst_still_idle", 128'(busy_o), 128'(0));
                next_cycle();
                return;
            end
        end

        // DONE
        stall_i = 1'b0;
        scramble();
        @(negedge clk);
        chk("done", 128'(done_o), 128'(1));
        chk("done_en", 128'(en_o), 128'(0));
        chk("done_busy", 128'(busy_o), 128'(1));
        chk("done_ready", 128'(req_ready_o), 128'(0));
        chk("done_load", 128'(load_o), 128'(0));
        check_cfg();
        next_cycle();
        req_valid_i = 2'b00;
    endtask

    // IDLE cycle with no request: nothing granted, config held.
    task automatic idle_cycle();
        req_valid_i = 2'b00;
        stall_i     = 1'($urandom_range(0, 1));
        rand_req(0);
        rand_req(1);
        @(negedge clk);
        chk("idle_ready", 128'(req_ready_o), 128'(0));
        chk("idle_busy", 128'(busy_o), 128'(0));
        chk("idle_done", 128'(done_o), 128'(0));
        chk("idle_en", 128'(en_o), 128'(0));
        check_cfg();
        next_cycle();
    endtask

    initial begin
        int rc;
        rst_i              = 1'b1;
        req_valid_i        = 2'b00;
        req_start_addr_i   = '0;
        req_vl_i           = '0;
        req_sew_i          = '0;
        req_slide_offset_i = '0;
        req_up_down_i      = '0;
        stall_i            = 1'b0;
        model_reset();
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("reset_busy", 128'(busy_o), 128'(0));
        chk("reset_load", 128'(load_o), 128'(0));
        chk("reset_done", 128'(done_o), 128'(0));
        chk("reset_en", 128'(en_o), 128'(0));
        check_cfg();
        next_cycle();
        rst_i = 1'b0;

        // Both valid from reset: requester 0 first, then requester 1.
        set_req(0, rand_addr(), 16, 2, 3, 1'b0);
        set_req(1, rand_addr(), 9, 1, 7, 1'b1);
        do_txn(1'b1, 1'b1, 0, 0, rc);
        set_req(0, rand_addr(), 16, 2, 3, 1'b0);
        set_req(1, rand_addr(), 9, 1, 7, 1'b1);
        do_txn(1'b1, 1'b1, 0, 0, rc);
        idle_cycle();

        // Single arith request, vl=64 word: 8 back-to-back enables.
        set_req(0, rand_addr(), 64, 2, 0, 1'b1);
        do_txn(1'b1, 1'b0, 0, 0, rc);
        chk("vl64_run_cycles", 128'(rc), 128'(8));

        // vl=20 with stall on RUN cycles 2 and 3: 3 enables over 5 cycles.
        set_req(1, rand_addr(), 20, 0, 0, 1'b1);
        do_txn(1'b0, 1'b1, 2, 0, rc);
        chk("vl20_run_cycles", 128'(rc), 128'(5));

        // Empty runs: vl=0 and illegal element width.
        set_req(0, rand_addr(), 0, 2, 0, 1'b1);
        do_txn(1'b1, 1'b0, 1, 0, rc);
        chk("vl0_run_cycles", 128'(rc), 128'(0));
        set_req(1, rand_addr(), 40, 3, 0, 1'b1);
        do_txn(1'b0, 1'b1, 1, 0, rc);
        chk("sew11_run_cycles", 128'(rc), 128'(0));

        // Slide configuration: offset 5, direction down.
        set_req(0, rand_addr(), 8, 2, 5, 1'b0);
        do_txn(1'b1, 1'b0, 0, 0, rc);
        idle_cycle();

        // Randomized traffic.
        for (int i = 0; i < 60; i++) begin
            bit v0;
            bit v1;
            rand_req(0);
            rand_req(1);
            v0 = 1'($urandom_range(0, 1));
            v1 = 1'($urandom_range(0, 1));
            if (!v0 && !v1) v0 = 1'b1;
            do_txn(v0, v1, 1, 0, rc);
            if ($urandom_range(0, 2) == 0) idle_cycle();
        end

        // Reset on the 4th RUN cycle, then arbitration restarts at requester 0.
        set_req(1, rand_addr(), 64, 2, 0, 1'b1);
        do_txn(1'b0, 1'b1, 0, 4, rc);
        set_req(0, rand_addr(), 8, 0, 1, 1'b0);
        set_req(1, rand_addr(), 8, 1, 2, 1'b1);
        do_txn(1'b1, 1'b1, 1, 0, rc);
        idle_cycle();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
